// File: rtl/riu_sequencer.sv
// riu_sequencer: multi-cycle control sequencer for RV32 R / I-ALU / LUI / AUIPC.
// Fetches over a req/ack handshake, then walks DECODE -> EXEC -> WB.
// Any encoding outside the supported set parks the sequencer in TRAP until reset.
module riu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [31:0] pc,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic        retired,
  output logic [31:0] retire_count,
  output logic        trap
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StTrap
  } state_e;

  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  localparam logic [6:0] F7Zero  = 7'b0000000;
  localparam logic [6:0] F7Alt   = 7'b0100000;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        alu_src_imm_q, alu_src_imm_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [31:0] retire_count_q, retire_count_d;

  logic        dec_legal;
  logic [3:0]  dec_alu_op;
  logic        dec_src_imm;
  logic [1:0]  dec_wb_sel;

  // Classify the held instruction from the externally decoded fields.
  always_comb begin
    dec_legal   = 1'b0;
    dec_alu_op  = 4'h0;
    dec_src_imm = 1'b0;
    dec_wb_sel  = 2'b00;
    case (opcode)
      OpReg: begin
        dec_legal  = (funct7 == F7Zero) ||
                     ((funct7 == F7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_alu_op = {funct7[5], funct3};
      end
      OpImm: begin
        dec_src_imm = 1'b1;
        // Only shift-right uses the qualifier; ADDI's imm bit 10 must not select SUB.
        dec_alu_op  = {(funct3 == 3'b101) && funct7[5], funct3};
        case (funct3)
          3'b001:  dec_legal = (funct7 == F7Zero);
          3'b101:  dec_legal = (funct7 == F7Zero) || (funct7 == F7Alt);
          default: dec_legal = 1'b1;
        endcase
      end
      OpLui: begin
        dec_legal  = 1'b1;
        dec_wb_sel = 2'b01;
      end
      OpAuipc: begin
        dec_legal  = 1'b1;
        dec_wb_sel = 2'b10;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and register updates for the sequencer.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    alu_op_d       = alu_op_q;
    alu_src_imm_d  = alu_src_imm_q;
    wb_sel_d       = wb_sel_q;
    retire_count_d = retire_count_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_legal) begin
          alu_op_d      = dec_alu_op;
          alu_src_imm_d = dec_src_imm;
          wb_sel_d      = dec_wb_sel;
          state_d       = StExec;
        end else begin
          state_d = StTrap;
        end
      end
      StExec: begin
        state_d = StWb;
      end
      StWb: begin
        pc_d           = pc_q + 32'd4;
        retire_count_d = retire_count_q + 32'd1;
        state_d        = run ? StFetch : StIdle;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath-control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pc_q           <= RESET_PC;
      instr_q        <= 32'h0;
      alu_op_q       <= 4'h0;
      alu_src_imm_q  <= 1'b0;
      wb_sel_q       <= 2'b00;
      retire_count_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      alu_op_q       <= alu_op_d;
      alu_src_imm_q  <= alu_src_imm_d;
      wb_sel_q       <= wb_sel_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Moore outputs decoded from state and registered fields.
  always_comb begin
    imem_req     = (state_q == StFetch);
    imem_addr    = pc_q;
    instr        = instr_q;
    pc           = pc_q;
    alu_op       = alu_op_q;
    alu_src_imm  = alu_src_imm_q;
    wb_sel       = wb_sel_q;
    rf_we        = (state_q == StWb);
    retired      = (state_q == StWb);
    retire_count = retire_count_q;
    trap         = (state_q == StTrap);
  end

endmodule

// File: tb/tb_riu_sequencer.sv
// Bench for riu_sequencer: a memory responder issues instructions and pushes the
// expected retirement/trap into a queue; an independent monitor pops and compares.
module tb_riu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic [1:0]  wb_sel;
  logic        rf_we;
  logic        retired;
  logic [31:0] retire_count;
  logic        trap;

  // Second instance exercising the pc wrap from the top of the address space.
  logic        w_run = 1'b0;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [3:0]  w_alu_op;
  logic        w_src;
  logic [1:0]  w_wb_sel;
  logic        w_rf_we;
  logic        w_retired;
  logic [31:0] w_retire_count;
  logic        w_trap;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  riu_sequencer u_dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .pc           (pc),
    .alu_op       (alu_op),
    .alu_src_imm  (alu_src_imm),
    .wb_sel       (wb_sel),
    .rf_we        (rf_we),
    .retired      (retired),
    .retire_count (retire_count),
    .trap         (trap)
  );

  riu_sequencer #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .clk          (clk),
    .rst          (rst),
    .run          (w_run),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ack     (w_req),
    .imem_rdata   (32'h0010_0093),
    .instr        (w_instr),
    .opcode       (w_instr[6:0]),
    .funct3       (w_instr[14:12]),
    .funct7       (w_instr[31:25]),
    .pc           (w_pc),
    .alu_op       (w_alu_op),
    .alu_src_imm  (w_src),
    .wb_sel       (w_wb_sel),
    .rf_we        (w_rf_we),
    .retired      (w_retired),
    .retire_count (w_retire_count),
    .trap         (w_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic        src;
    logic [1:0]  wb;
    bit          chk_alu;
    logic [31:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [64];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          fetch_count = 0;
  int          retired_n   = 0;
  int          model_n     = 0;
  logic [31:0] model_pc    = 32'h0;
  int          force_wait  = -1;
  bit          trap_seen   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference classifier written straight from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                     output logic [3:0] aop, output logic src,
                                     output logic [1:0] wb, output bit chk_alu);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    legal = 1'b0; aop = 4'h0; src = 1'b0; wb = 2'b00; chk_alu = 1'b1;
    if (op == 7'h33) begin
      if (f7 == 7'h00) legal = 1'b1;
      if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) legal = 1'b1;
      aop = (f7 == 7'h20) ? 4'd8 + 4'(f3) : 4'(f3);
    end else if (op == 7'h13) begin
      src = 1'b1;
      if (f3 == 3'd1) legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
      else legal = 1'b1;
      aop = (f3 == 3'd5 && f7 == 7'h20) ? 4'd13 : 4'(f3);
    end else if (op == 7'h37) begin
      legal = 1'b1; wb = 2'b01; chk_alu = 1'b0;
    end else if (op == 7'h17) begin
      legal = 1'b1; wb = 2'b10; chk_alu = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          k;
    k  = int'($urandom_range(0, 3));
    w  = $urandom;
    f3 = 3'($urandom_range(0, 7));
    f7 = 7'($urandom_range(0, 127));
    if (k == 0) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      w  = {f7, w[24:15], f3, w[11:7], 7'h33};
    end else if (k == 1) begin
      if (f3 == 3'd1) f7 = 7'h00;
      if (f3 == 3'd5) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      w = {f7, w[24:15], f3, w[11:7], 7'h13};
    end else if (k == 2) begin
      w = {w[31:7], 7'h37};
    end else begin
      w = {w[31:7], 7'h17};
    end
    return w;
  endfunction

  function automatic int pick_wait(input logic [31:0] addr);
    if (force_wait >= 0) return force_wait;
    if (addr < 32'h14) return 0;
    if (addr == 32'h14) return 3;
    return int'($urandom_range(0, 2));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: acks after a chosen wait and records the expected outcome.
  initial begin : responder
    int   waits_left;
    bit   busy;
    exp_t e;
    bit   legal;
    waits_left = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_ack = 1'b0;
        busy = 1'b0;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        chk("req_falls_after_ack", 32'(imem_req), 32'h0);
      end else if (imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          waits_left = pick_wait(imem_addr);
        end
        chk("imem_addr", imem_addr, model_pc);
        if (waits_left == 0) begin
          imem_rdata = mem[imem_addr[7:2]];
          imem_ack = 1'b1;
          busy = 1'b0;
          ref_decode(imem_rdata, legal, e.alu_op, e.src, e.wb, e.chk_alu);
          e.is_trap = !legal;
          e.pc = model_pc;
          e.cnt = 32'(model_n);
          e.cyc = cyc;
          q.push_back(e);
          fetch_count++;
          if (legal) begin
            model_n++;
            model_pc = model_pc + 32'd4;
          end
        end else begin
          waits_left--;
        end
      end
    end
  end

  // Monitor: compare every retirement and trap entry against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        trap_seen = 1'b0;
      end else begin
        if (rf_we) begin
          if (q.size() == 0) begin
            chk("unexpected_rf_we", 32'(rf_we), 32'h0);
          end else begin
            e = q.pop_front();
            retired_n++;
            chk("wb_is_not_trap", 32'(e.is_trap), 32'h0);
            chk("wb_pc", pc, e.pc);
            chk("wb_retired", 32'(retired), 32'h1);
            chk("wb_retire_count", retire_count, e.cnt);
            chk("wb_latency", 32'(cyc), 32'(e.cyc + 3));
            chk("wb_sel", 32'(wb_sel), 32'(e.wb));
            if (e.chk_alu) begin
              chk("alu_op", 32'(alu_op), 32'(e.alu_op));
              chk("alu_src_imm", 32'(alu_src_imm), 32'(e.src));
            end
          end
        end
        if (trap && !trap_seen) begin
          trap_seen = 1'b1;
          if (q.size() == 0) begin
            chk("unexpected_trap", 32'(trap), 32'h0);
          end else begin
            e = q.pop_front();
            chk("trap_expected", 32'(e.is_trap), 32'h1);
            chk("trap_pc", pc, e.pc);
            chk("trap_latency", 32'(cyc), 32'(e.cyc + 2));
            chk("trap_no_req", 32'(imem_req), 32'h0);
          end
        end
      end
    end
  end

  // Wrap instance: first rf_we at cycle 4 after reset release, pc wraps to zero.
  initial begin : wrap_check
    int n;
    @(negedge rst);
    w_run = 1'b1;
    n = 0;
    while (n < 20 && !w_rf_we) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_first_rf_we", 32'(w_rf_we), 32'h1);
    chk("wrap_first_rf_we_cycle", 32'(n), 32'd4);
    chk("wrap_wb_pc", w_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    w_run = 1'b0;
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_retire_count", w_retire_count, 32'h1);
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    q.delete();
    model_pc = 32'h0;
    model_n = 0;
    retired_n = 0;
  endtask

  logic [31:0] ill [3];

  initial begin : main
    int n;
    ill[0] = 32'h0000_2083;
    ill[1] = 32'h4020_9133;
    ill[2] = 32'h4030_9193;
    for (int i = 0; i < 64; i++) mem[i] = rand_legal();
    mem[0]  = 32'h0020_81B3;
    mem[1]  = 32'h4020_81B3;
    mem[2]  = 32'h4020_D193;
    mem[3]  = 32'hC000_8193;
    mem[4]  = 32'h1234_50B7;
    mem[16] = 32'h0000_1117;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_alu_src_imm", 32'(alu_src_imm), 32'h0);
    chk("rst_wb_sel", 32'(wb_sel), 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    chk("rst_retire_count", retire_count, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_holds_no_req", 32'(imem_req), 32'h0);
    run = 1'b1;

    // Drop run during EXEC of the 21st instruction.
    n = 0;
    while (n < 1000 && fetch_count < 21) begin
      @(posedge clk);
      n++;
    end
    chk("reached_fetch_21", 32'(fetch_count >= 21), 32'h1);
    @(posedge clk);
    #1 run = 1'b0;
    repeat (6) @(negedge clk);
    chk("run_drop_idle_req", 32'(imem_req), 32'h0);
    chk("run_drop_pc", pc, model_pc);
    chk("run_drop_retire_count", retire_count, 32'(model_n));
    chk("run_drop_queue_empty", 32'(q.size()), 32'h0);
    run = 1'b1;

    n = 0;
    while (n < 3000 && retired_n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("retired_40", 32'(retired_n >= 40), 32'h1);
    run = 1'b0;
    repeat (12) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    chk("final_retire_count", retire_count, 32'(model_n));

    // Asynchronous reset in the middle of a stalled fetch.
    force_wait = 8;
    run = 1'b1;
    n = 0;
    while (n < 20 && !imem_req) begin
      @(negedge clk);
      n++;
    end
    chk("mid_fetch_req_seen", 32'(imem_req), 32'h1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'h0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_retire_count", retire_count, 32'h0);
    chk("async_rst_wb_sel", 32'(wb_sel), 32'h0);
    chk("async_rst_alu_op", 32'(alu_op), 32'h0);
    run = 1'b0;
    force_wait = -1;
    reset_model();
    @(negedge clk);
    rst = 1'b0;

    // Illegal encodings at pc 0x8 trap and stay trapped.
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      rst = 1'b1;
      reset_model();
      mem[2] = ill[t];
      @(negedge clk);
      rst = 1'b0;
      run = 1'b1;
      n = 0;
      while (n < 60 && !trap) begin
        @(negedge clk);
        n++;
      end
      chk("trap_reached", 32'(trap), 32'h1);
      repeat (5) @(negedge clk);
      run = 1'b0;
      repeat (2) @(negedge clk);
      chk("trap_sticky", 32'(trap), 32'h1);
      chk("trap_pc_frozen", pc, 32'h8);
      chk("trap_req_low", 32'(imem_req), 32'h0);
      chk("trap_rf_we_low", 32'(rf_we), 32'h0);
      chk("trap_retire_count", retire_count, 32'h2);
      chk("trap_queue_empty", 32'(q.size()), 32'h0);
    end
    rst = 1'b1;
    reset_model();
    @(negedge clk);
    chk("rst_clears_trap", 32'(trap), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riu_sequencer.md
# riu_sequencer

Multi-cycle control sequencer for the RV32 register/immediate/upper-immediate (R, I-ALU, LUI, AUIPC) datapath. Fetches each instruction over a req/ack instruction-memory handshake and holds it in an instruction register that feeds the field decoder. It then sequences decode, execute and write-back, driving ALU operation, operand select, write-back select and register-file write enable. It also tracks the program counter and a retired-instruction count, and traps on any unsupported encoding.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; allows leaving IDLE and continuing after WB
- imem_req  out  1  fetch request, held high for the whole FETCH state
- imem_addr  out  32  fetch address; equals pc
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  instruction register, drives the field decoder
- opcode  in  7  decoded instr[6:0]
- funct3  in  3  decoded instr[14:12]
- funct7  in  7  decoded instr[31:25]; also imm12[11:5] for I-type
- pc  out  32  current instruction address
- alu_op  out  4  {funct7[5] qualifier, funct3}
- alu_src_imm  out  1  1 selects sign-extended imm12 as ALU operand B
- wb_sel  out  2  00 ALU result, 01 imm20<<12 (LUI), 10 pc+(imm20<<12) (AUIPC)
- rf_we  out  1  register-file write enable, one cycle per retired instruction
- retired  out  1  one-cycle pulse, concurrent with rf_we
- retire_count  out  32  retired-instruction counter
- trap  out  1  sticky illegal-instruction flag

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP. Outputs are Moore, decoded from state and registered fields.
- IDLE: moves to FETCH when run=1; otherwise stays.
- FETCH: imem_req=1 with imem_addr=pc. When imem_ack=1: instr<=imem_rdata and the state moves to DECODE. Otherwise the state holds and imem_addr stays stable.
- DECODE: classifies the instruction and registers alu_op, alu_src_imm, wb_sel and a legal flag.
  - Opcode 0110011 (R-type): alu_src_imm=0, wb_sel=00.
    - Legal if funct7=0000000.
    - Also legal if funct7=0100000 with funct3 000 or 101.
    - alu_op={funct7[5],funct3}.
  - Opcode 0010011 (I-ALU): alu_src_imm=1, wb_sel=00.
    - funct3=001 is legal only if funct7=0000000.
    - funct3=101 is legal only if funct7 is 0000000 or 0100000.
    - alu_op[3] = funct7[5] when funct3=101, otherwise 0. ADDI never becomes SUB.
  - Opcode 0110111 (LUI): wb_sel=01.
  - Opcode 0010111 (AUIPC): wb_sel=10.
  - Any other opcode, or an illegal qualifier: next state is TRAP.
- EXEC: one cycle; control outputs are held so datapath results settle.
- WB: rf_we=1 and retired=1 for exactly one cycle.
  - pc<=pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - retire_count<=retire_count+1, wrapping.
  - Next state is FETCH if run=1, else IDLE.
- TRAP: trap=1, rf_we=0, pc frozen at the faulting address, imem_req=0. Exited only by rst.
- run is sampled only in IDLE and WB. Deasserting run mid-instruction still completes that instruction.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, instr=32'h0.
  - alu_op=0, alu_src_imm=0, wb_sel=00.
  - rf_we=0, retired=0, imem_req=0, trap=0, retire_count=0.
- Asynchronous reset mid-fetch drops imem_req immediately. A late ack after reset is ignored because the state is not FETCH.
- Minimum instruction period is 4 cycles: FETCH (ack in its first cycle), DECODE, EXEC, WB. Each extra ack wait adds one cycle.
- imem_req rises in the first FETCH cycle and falls the cycle after the ack edge.
- alu_op, alu_src_imm and wb_sel are valid from the first EXEC cycle through the end of WB.
- rf_we samples the datapath result on the WB-to-next edge.
- pc increments on the WB exit edge. AUIPC therefore uses the pre-increment pc.
- trap rises on the DECODE-to-TRAP edge. No rf_we is issued for the faulting instruction.
- From reset release with run=1: first imem_req in cycle 1 (IDLE→FETCH), first rf_we in cycle 4 with zero wait states.

## Test plan
- ADD then SUB: run=1, zero-wait memory returning 0x002081B3 then 0x402081B3.
  - alu_op=0000 then 1000, alu_src_imm=0, wb_sel=00.
  - rf_we pulses 4 cycles apart; pc goes 0→4→8; retire_count=2.
- I-type: SRAI 0x4020D193 → alu_op=1101, alu_src_imm=1. ADDI with imm=-1024 (0xC0008193) → alu_op=0000, not 1000.
- LUI 0x123450B7 gives wb_sel=01. AUIPC 0x00001117 at pc=0x40 gives wb_sel=10, with pc still 0x40 during WB and then 0x44.
- Illegal instructions trap: opcode 0000011 at pc=0x8, R-type with funct7=0100000 and funct3=001, and SLLI with funct7=0100000.
  - trap=1, no rf_we, pc stays 0x8, imem_req=0.
  - Only rst clears trap.
- Handshake and run:
  - ack delayed 3 cycles: imem_req and imem_addr stay stable for 4 cycles, instruction period is 7.
  - run dropped in EXEC: WB completes, then IDLE; reasserting run resumes at pc+4.
- Boundaries: RESET_PC=0xFFFF_FFFC wraps pc to 0 after one retire. rst asserted mid-FETCH clears all outputs asynchronously.
